// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Multi-cycle control unit for the 9-bit processor. It steps each
//            instruction through fetch/decode/exec/mem/wb with handshakes.
// Revision : 1.0  initial multi-cycle release
// ============================================================================
module multicycle_control #(
    parameter int                  MCODEBITS   = 9,
    parameter int                  OPWIDTH     = 3,
    parameter int                  MEM_TIMEOUT = 8,
    parameter logic [OPWIDTH-1:0]  ADDR_ALUOP  = 3'b000,
    parameter logic [OPWIDTH-1:0]  CMP_ALUOP   = 3'b110,
    parameter int                  CNTW        = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [MCODEBITS-1:0] instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic                 mem_ready,
    input  logic                 branch_taken,
    output logic                 RegDst,
    output logic                 Branch,
    output logic                 MemtoReg,
    output logic                 MemWrite,
    output logic                 MemRead,
    output logic                 ALUSrc,
    output logic                 RegWrite,
    output logic                 PCWrite,
    output logic [OPWIDTH-1:0]   ALUOp,
    output logic                 Done,
    output logic                 Error,
    output logic [2:0]           state_o,
    output logic [CNTW-1:0]      retired
);

    localparam int                c_waitw     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [c_waitw-1:0] c_wait_last = c_waitw'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t               r_state;
    logic [2:0]           r_op;
    logic [1:0]           r_sub;
    logic [c_waitw-1:0]   r_wait;
    logic [CNTW-1:0]      r_retired;
    logic                 r_done;
    logic                 r_error;

    logic                 w_is_load;
    logic                 w_is_store;
    logic                 w_is_branch;
    logic [OPWIDTH-1:0]   w_exec_aluop;
    logic                 w_exec_alusrc;

    // Only opcode and subfunction steer control; the operand field is the datapath's.
    generate
        if (MCODEBITS > 5) begin : g_unused_bits
            logic w_unused_operand;
            assign w_unused_operand = ^instr[MCODEBITS-6:0];
        end
    endgenerate

    assign w_is_load   = (r_op == 3'b000) && (r_sub == 2'b10);
    assign w_is_store  = (r_op == 3'b000) && (r_sub == 2'b11);
    assign w_is_branch = (r_op == 3'b010);

    always_comb begin
        w_exec_aluop  = OPWIDTH'(r_op);
        w_exec_alusrc = 1'b0;
        case (r_op)
            3'b000: begin
                if (r_sub[1]) begin
                    w_exec_aluop  = ADDR_ALUOP;
                    w_exec_alusrc = 1'b1;
                end else begin
                    w_exec_aluop  = OPWIDTH'(r_sub[0]);
                end
            end
            3'b001: begin
                w_exec_aluop  = OPWIDTH'(r_sub);
                w_exec_alusrc = 1'b1;
            end
            3'b010:  w_exec_aluop = CMP_ALUOP;
            default: w_exec_aluop = OPWIDTH'(r_op);
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        RegDst      = 1'b0;
        Branch      = 1'b0;
        MemtoReg    = 1'b0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        ALUSrc      = 1'b0;
        RegWrite    = 1'b0;
        PCWrite     = 1'b0;
        ALUOp       = '1;
        case (r_state)
            S_FETCH: instr_ready = 1'b1;
            S_EXEC: begin
                ALUOp  = w_exec_aluop;
                ALUSrc = w_exec_alusrc;
                if (w_is_branch) begin
                    Branch  = branch_taken;
                    PCWrite = 1'b1;
                end
            end
            S_MEM: begin
                ALUOp    = w_exec_aluop;
                ALUSrc   = w_exec_alusrc;
                MemRead  = w_is_load;
                MemWrite = w_is_store;
                PCWrite  = w_is_store && mem_ready;
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = w_is_load;
                PCWrite  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_sub     <= '0;
            r_wait    <= '0;
            r_retired <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (instr_valid) begin
                        r_op    <= instr[MCODEBITS-1 -: 3];
                        r_sub   <= instr[MCODEBITS-4 -: 2];
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (r_op == 3'b111) begin
                        r_done  <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_is_load || w_is_store) r_state <= S_MEM;
                    else if (w_is_branch)        r_state <= S_FETCH;
                    else                         r_state <= S_WB;
                end
                S_MEM: begin
                    // A completion on the last allowed cycle beats the timeout.
                    if (mem_ready) begin
                        r_wait  <= '0;
                        r_state <= w_is_store ? S_FETCH : S_WB;
                    end else if (r_wait == c_wait_last) begin
                        r_wait  <= '0;
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_HALT;
                    end else begin
                        r_wait  <= r_wait + c_waitw'(1);
                    end
                end
                S_WB:    r_state <= S_FETCH;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
            if (PCWrite) r_retired <= r_retired + CNTW'(1);
        end
    end

    assign Done    = r_done;
    assign Error   = r_error;
    assign state_o = r_state;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Randomized self-checking bench for multicycle_control against an
//            instruction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_control;

    localparam int MCODEBITS   = 9;
    localparam int OPWIDTH     = 3;
    localparam int MEM_TIMEOUT = 8;
    localparam int CNTW        = 16;

    logic                 Clk = 1'b0;
    logic                 Reset;
    logic                 start;
    logic [MCODEBITS-1:0] instr;
    logic                 instr_valid;
    logic                 instr_ready;
    logic                 mem_ready;
    logic                 branch_taken;
    logic                 RegDst, Branch, MemtoReg, MemWrite, MemRead, ALUSrc, RegWrite, PCWrite;
    logic [OPWIDTH-1:0]   ALUOp;
    logic                 Done, Error;
    logic [2:0]           state_o;
    logic [CNTW-1:0]      retired;

    multicycle_control #(
        .MCODEBITS(MCODEBITS), .OPWIDTH(OPWIDTH), .MEM_TIMEOUT(MEM_TIMEOUT),
        .ADDR_ALUOP(3'b000), .CMP_ALUOP(3'b110), .CNTW(CNTW)
    ) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .mem_ready(mem_ready), .branch_taken(branch_taken),
        .RegDst(RegDst), .Branch(Branch), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .MemRead(MemRead), .ALUSrc(ALUSrc),
        .RegWrite(RegWrite), .PCWrite(PCWrite), .ALUOp(ALUOp),
        .Done(Done), .Error(Error), .state_o(state_o), .retired(retired)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int m_retired = 0;
    bit m_done    = 1'b0;
    bit m_error   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Strobe vector order: {RegDst, Branch, MemtoReg, MemWrite, MemRead, ALUSrc, RegWrite, PCWrite}
    function automatic logic [7:0] strb(input bit br, input bit mtr, input bit mw, input bit mr,
                                        input bit as, input bit rw, input bit pc);
        return {1'b0, br, mtr, mw, mr, as, rw, pc};
    endfunction

    function automatic logic [2:0] ref_aluop(input logic [2:0] op, input logic [1:0] sub);
        if (op == 3'd0) return (sub == 2'd1) ? 3'd1 : 3'd0;
        if (op == 3'd1) return {1'b0, sub};
        if (op == 3'd2) return 3'b110;
        return op;
    endfunction

    function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] sub);
        logic [3:0] low;
        low = 4'($urandom);
        return {op, sub, low};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic cyc(input string tag, input int st, input logic [7:0] s,
                       input logic [2:0] aop, input bit irdy);
        #2;
        check({tag, "_state"}, 32'(state_o), 32'(st));
        check({tag, "_strb"},  32'({RegDst, Branch, MemtoReg, MemWrite, MemRead, ALUSrc, RegWrite, PCWrite}), 32'(s));
        check({tag, "_aluop"}, 32'(ALUOp), 32'(aop));
        check({tag, "_irdy"},  32'(instr_ready), 32'(irdy));
        check({tag, "_ret"},   32'(retired), 32'(CNTW'(m_retired)));
        check({tag, "_done"},  32'(Done), 32'(m_done));
        check({tag, "_err"},   32'(Error), 32'(m_error));
    endtask

    // Runs one instruction from its FETCH cycle; mem completes after nwait stalls.
    task automatic run_instr(input logic [8:0] ins, input int stalls, input int nwait, input bit bt);
        logic [2:0] op;
        logic [1:0] sub;
        logic [2:0] aop;
        bit ld, st, as, rdy;
        op  = ins[8:6];
        sub = ins[5:4];
        ld  = (op == 3'd0) && (sub == 2'd2);
        st  = (op == 3'd0) && (sub == 2'd3);
        as  = (op == 3'd1) || ld || st;
        aop = ref_aluop(op, sub);
        for (int i = 0; i < stalls; i++) begin
            instr_valid = 1'b0;
            instr = 9'($urandom);
            start = 1'($urandom);
            cyc("fetch_wait", 1, 8'h00, 3'b111, 1'b1);
            tick();
        end
        instr_valid = 1'b1;
        instr = ins;
        cyc("fetch", 1, 8'h00, 3'b111, 1'b1);
        tick();
        instr_valid = 1'b0;
        instr = 9'($urandom);
        cyc("decode", 2, 8'h00, 3'b111, 1'b0);
        tick();
        if (op == 3'd7) begin
            m_done = 1'b1;
            return;
        end
        branch_taken = bt;
        if (op == 3'd2) begin
            cyc("exec_br", 3, strb(bt, 0, 0, 0, 0, 0, 1), aop, 1'b0);
            tick();
            m_retired++;
            return;
        end
        cyc("exec", 3, strb(0, 0, 0, 0, as, 0, 0), aop, 1'b0);
        tick();
        if (ld || st) begin
            for (int k = 0; k < MEM_TIMEOUT; k++) begin
                rdy = (k == nwait);
                mem_ready = rdy;
                cyc("mem", 4, strb(0, 0, st, ld, 1, 0, st && rdy), aop, 1'b0);
                tick();
                mem_ready = 1'b0;
                if (rdy) break;
                if (k == MEM_TIMEOUT - 1) begin
                    m_error = 1'b1;
                    m_done  = 1'b1;
                    return;
                end
            end
            if (st) begin
                m_retired++;
                return;
            end
        end
        cyc("wb", 5, strb(0, ld, 0, 0, 0, 1, 1), 3'b111, 1'b0);
        tick();
        m_retired++;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        m_retired = 0;
        m_done    = 1'b0;
        m_error   = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        cyc("idle", 0, 8'h00, 3'b111, 1'b0);
        tick();
        start = 1'b0;
    endtask

    logic [8:0] ins;
    int         cls;

    initial begin
        Reset = 1'b1; start = 1'b0; instr = '0; instr_valid = 1'b0;
        mem_ready = 1'b0; branch_taken = 1'b0;
        tick();
        tick();
        cyc("reset", 0, 8'h00, 3'b111, 1'b0);
        Reset = 1'b0;
        tick();
        go();

        run_instr(mk(3'd0, 2'd1), 0, 0, 1'b0);
        run_instr(mk(3'd0, 2'd2), 0, 2, 1'b0);
        run_instr(mk(3'd2, 2'($urandom)), 0, 0, 1'b1);
        run_instr(mk(3'd2, 2'($urandom)), 0, 0, 1'b0);
        run_instr(mk(3'd0, 2'd3), 1, MEM_TIMEOUT - 1, 1'b0);
        run_instr(mk(3'd0, 2'd2), 0, MEM_TIMEOUT - 1, 1'b0);

        for (int n = 0; n < 60; n++) begin
            cls = $urandom_range(0, 5);
            case (cls)
                0: ins = mk(3'd0, 2'($urandom_range(0, 1)));
                1: ins = mk(3'd1, 2'($urandom));
                2: ins = mk(3'd2, 2'($urandom));
                3: ins = mk(3'd0, 2'd2);
                4: ins = mk(3'd0, 2'd3);
                default: ins = mk(3'($urandom_range(3, 6)), 2'($urandom));
            endcase
            run_instr(ins, $urandom_range(0, 2), $urandom_range(0, MEM_TIMEOUT - 1), 1'($urandom));
        end

        // Asynchronous reset while a store is stalled in MEM.
        instr_valid = 1'b1; instr = mk(3'd0, 2'd3);
        tick();
        instr_valid = 1'b0;
        tick();
        tick();
        repeat (3) tick();
        check("midmem_state_pre", 32'(state_o), 32'd4);
        check("midmem_mw_pre", 32'(MemWrite), 32'd1);
        Reset = 1'b1;
        m_retired = 0;
        cyc("midmem_rst", 0, 8'h00, 3'b111, 1'b0);
        tick();
        Reset = 1'b0;
        tick();
        go();

        run_instr(mk(3'd4, 2'($urandom)), 0, 0, 1'b0);
        run_instr(mk(3'd0, 2'd3), 0, 1000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            start = 1'b1;
            instr_valid = 1'($urandom);
            cyc("timeout_halt", 6, 8'h00, 3'b111, 1'b0);
            tick();
        end
        start = 1'b0;

        do_reset();
        go();
        for (int i = 0; i < 3; i++)
            run_instr(mk(3'($urandom_range(3, 6)), 2'($urandom)), 0, 0, 1'b0);
        run_instr(mk(3'd7, 2'($urandom)), 5, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom);
            instr_valid = 1'b1;
            cyc("halt", 6, 8'h00, 3'b111, 1'b0);
            tick();
        end
        check("halt_retired", 32'(retired), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Parametrised multi-cycle control unit for the 9-bit processor; successor to the single-cycle combinational control decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback states with a valid/ready instruction handshake and a memory-ready wait with timeout.
- Drives the same datapath strobes as before, plus PC-write, memory-read, done/error status and a retired-instruction counter.

Parameters:
MCODEBITS, 9, instruction width; opcode = instr[MCODEBITS-1 -: 3], subfunction = instr[MCODEBITS-4 -: 2]
OPWIDTH, 3, ALUOp width
MEM_TIMEOUT, 8, consecutive MEM cycles without mem_ready before error
ADDR_ALUOP, 3'b000, ALUOp used for load/store address calculation
CMP_ALUOP, 3'b110, ALUOp used for branch compare
CNTW, 16, width of retired-instruction counter

Ports:
Clk  input  1  clock, all state on rising edge
Reset  input  1  asynchronous, active-high reset
start  input  1  leave IDLE
instr  input  MCODEBITS  instruction from instruction memory
instr_valid  input  1  instr is valid this cycle
instr_ready  output  1  control accepts instr (FETCH only)
mem_ready  input  1  data memory completes current access
branch_taken  input  1  ALU compare result, sampled in EXEC
RegDst, Branch, MemtoReg, MemWrite, MemRead, ALUSrc, RegWrite, PCWrite  output  1 each  datapath strobes
ALUOp  output  OPWIDTH  ALU operation select
Done  output  1  sticky halt indication
Error  output  1  sticky memory-timeout indication
state_o  output  3  current state encoding, for debug
retired  output  CNTW  count of retired instructions

Behaviour:
- Reset (async, any state, including mid-MEM): state=IDLE, IR=0, wait_cnt=0, retired=0, Done=0, Error=0. All strobes 0, ALUOp='1 (pass-through), instr_ready=0.
- Outputs are Moore: a combinational function of state and the latched IR; Branch and PCWrite additionally depend on branch_taken/mem_ready in the states noted below.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE: start=1 -> FETCH next cycle.
- FETCH: instr_ready=1. On instr_valid=1, latch IR and go to DECODE; otherwise hold in FETCH indefinitely.
- DECODE: one cycle. Opcode 111 -> HALT; otherwise -> EXEC.
- EXEC, ALUOp/ALUSrc by opcode:
  - 000 with sub 00 -> ALUOp=0.
  - 000 with sub 01 -> ALUOp=1.
  - 000 with sub 10 (load) or sub 11 (store) -> ALUOp=ADDR_ALUOP, ALUSrc=1.
  - 001 -> ALUSrc=1, ALUOp=zero-extended sub.
  - 010 (branch) -> ALUOp=CMP_ALUOP.
  - 011..110 -> ALUOp=opcode.
- EXEC, next state:
  - Load/store -> MEM.
  - Branch: Branch=branch_taken, PCWrite=1, retire, -> FETCH.
  - All others -> WB.
- MEM: ALUOp/ALUSrc held from EXEC. MemRead=1 (load) or MemWrite=1 (store) for every MEM cycle.
  - mem_ready=1 on a store: PCWrite=1, retire, -> FETCH.
  - mem_ready=1 on a load: -> WB.
  - mem_ready=0: wait_cnt++. When wait_cnt reaches MEM_TIMEOUT-1 and mem_ready is still 0, set Error=1 and go to HALT; no retire.
  - wait_cnt clears on leaving MEM.
- WB: RegWrite=1, MemtoReg=1 for a load, PCWrite=1, retire, -> FETCH.
- HALT: Done=1 (sticky), all strobes 0, start ignored. Only Reset exits HALT.
- Retire: retired++ in the same cycle PCWrite=1; wraps modulo 2^CNTW. Halt instructions are not counted.
- RegDst is always 0 (in-place writes).
- Latency:
  - ALU op = 4 cycles (FETCH/DECODE/EXEC/WB), with valid held.
  - Branch = 3 cycles.
  - Store = 4 + N wait cycles.
  - Load = 5 + N wait cycles.
- Simultaneous events:
  - mem_ready on the same cycle wait_cnt hits its limit: the completion wins, no Error.
  - start asserted outside IDLE: ignored.

Test Plan:
- Reset mid-MEM (store, mem_ready=0, 3 wait cycles) -> next cycle state_o=0, MemWrite=0, ALUOp=3'b111, retired=0.
- start, instr=9'b000_01_xxxx with valid held -> EXEC shows ALUOp=1, ALUSrc=0; WB shows RegWrite=1, PCWrite=1; retired=1 after 4 cycles; state_o back to 1.
- Load 9'b000_10_xxxx with mem_ready low 2 cycles -> MemRead=1 for 3 MEM cycles, then WB with MemtoReg=1, RegWrite=1; total 7 cycles.
- Branch 9'b010_xxxxxx twice, with branch_taken=1 then 0 -> Branch=1 then 0; PCWrite=1 both; ALUOp=3'b110; retired +2.
- Store with mem_ready held low, MEM_TIMEOUT=8 -> after 8 MEM cycles Error=1, Done=1, state_o=6, retired unchanged; start ignored.
- Halt 9'b111_xxxxxx after 3 ALU ops -> Done=1, retired=3, instr_ready=0 thereafter; instr_valid held 0 in FETCH for 5 cycles beforehand -> stays in FETCH, no retire.
